wbu: RTL and testbench
======================

WBU -- requirements
Module: wbu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning register/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid_i  input  1  execute-stage result packet valid.
REQ-005 SHALL have port in_ready_o  output  1  wbu can accept a packet this cycle.
REQ-006 SHALL have port alu_res_i  input  DATA_WIDTH  ALU result; for loads, the effective address.
REQ-007 SHALL have port rd_i  input  5  destination register index.
REQ-008 SHALL have port wen_i  input  1  instruction writes rd.
REQ-009 SHALL have port is_load_i  input  1  instruction is a load.
REQ-010 SHALL have port ld_funct3_i  input  3  load funct3 (LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=5, LWU=6).
REQ-011 SHALL have port mem_rvalid_i  input  1  load data response valid.
REQ-012 SHALL have port mem_rdata_i  input  DATA_WIDTH  naturally aligned 8-byte word containing the load address.
REQ-013 SHALL have port rf_wen_o  output  1  register file write enable.
REQ-014 SHALL have port rf_waddr_o  output  5  register file write index.
REQ-015 SHALL have port rf_wdata_o  output  DATA_WIDTH  register file write data.
REQ-016 SHALL have port retire_o  output  1  one-cycle pulse per completed instruction.
REQ-017 SHALL have port instret_o  output  64  retired-instruction count (present only per REQ-033).

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_MEM, WB.
REQ-019 SHALL drive in_ready_o = 1 in IDLE and WB, 0 in WAIT_MEM; a transfer occurs when in_valid_i && in_ready_o.
REQ-020 SHALL, on a transfer with is_load_i=0, register rd/wen/alu_res and enter WB next cycle (latency 1).
REQ-021 SHALL, on a transfer with is_load_i=1, register rd/wen/funct3/alu_res[2:0] and enter WAIT_MEM.
REQ-022 SHALL, in WAIT_MEM, stay until mem_rvalid_i=1, then register the extracted load value and enter WB next cycle.
REQ-023 SHALL ignore mem_rvalid_i in IDLE and WB.
REQ-024 SHALL, in WB, assert retire_o=1 and rf_wen_o = wen && (rd != 0) for exactly one cycle, with rf_waddr_o=rd and rf_wdata_o=result.
REQ-025 SHALL, leaving WB, go to IDLE if no transfer, else to WB/WAIT_MEM per REQ-020/021 (back-to-back ALU ops retire at 1 per cycle).
REQ-026 SHALL extract load data as: offset = alu_res[2:0] masked to size alignment (byte: none, half: clear bit0, word: clear bits1:0, double: 0); field = mem_rdata_i >> (offset*8), truncated to size.
REQ-027 SHALL sign-extend for LB/LH/LW, zero-extend for LBU/LHU/LWU, pass through for LD; funct3=7 yields 0.
REQ-028 SHALL hold rf_wen_o=0, retire_o=0 outside WB; rf_waddr_o/rf_wdata_o hold last value.

Reset
REQ-029 SHALL, on rst_n=0 (any time, including mid-WAIT_MEM), force state IDLE, rf_wen_o=0, retire_o=0, rf_waddr_o=0, rf_wdata_o=0, instret_o=0; a pending load is dropped.
REQ-030 SHALL drive in_ready_o=1 on the first cycle after reset release.

Configuration
REQ-031 SHALL gate the retire counter with macro WBU_PERF_CNT_EN.
REQ-032 SHALL, with WBU_PERF_CNT_EN defined, increment instret_o by 1 each cycle retire_o=1, wrapping 2^64-1 -> 0.
REQ-033 SHALL, without WBU_PERF_CNT_EN, omit instret_o port and counter entirely; all other behaviour unchanged.

Structure
REQ-034 SHALL place the FSM state enum and load funct3 constants in shared package rv_pkg.
REQ-035 SHALL implement extraction (REQ-026/027) in combinational sub-module load_align.

Verification
REQ-036 SHALL test: ALU op alu_res=0x1234, rd=5, wen=1 -> next cycle rf_wen_o=1, waddr=5, wdata=0x1234, retire_o=1.
REQ-037 SHALL test: three back-to-back ALU ops, in_valid held high -> three consecutive write cycles, in_ready_o never low.
REQ-038 SHALL test: LB addr[2:0]=3, mem_rdata=0x00000000_80000000 delayed 4 cycles -> in_ready_o=0 during wait; write 0xFFFFFFFF_FFFFFF80 one cycle after mem_rvalid_i; LBU same -> 0x80.
REQ-039 SHALL test: wen=1, rd=0 -> rf_wen_o=0, retire_o=1.
REQ-040 SHALL test: rst_n low during WAIT_MEM, then late mem_rvalid_i -> no write, state IDLE, in_ready_o=1.
REQ-041 SHALL test (WBU_PERF_CNT_EN): 10 retirements -> instret_o=10; preload 2^64-1, retire once -> 0.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared writeback FSM states and load funct3 encodings
package rv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WB       = 2'd2
  } wbu_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  // Byte offset inside the 8-byte word, forced down to the access size alignment.
  function automatic logic [2:0] align_offset(input logic [2:0] funct3, input logic [2:0] addr);
    logic [2:0] off;
    case (funct3[1:0])
      2'd0:    off = addr;
      2'd1:    off = {addr[2:1], 1'b0};
      2'd2:    off = {addr[2], 2'b00};
      default: off = 3'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load data extraction and sign/zero extension
module load_align
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [2:0]            addr_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [2:0]            offset;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    offset  = align_offset(funct3_i, addr_i);
    shifted = rdata_i >> {offset, 3'b000};
    data_o  = '0;
    case (funct3_i)
      F3_LB:   data_o = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   data_o = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      F3_LD:   data_o = shifted;
      F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      F3_LWU:  data_o = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/wbu.sv
// rtl/wbu.sv - writeback unit: retires ALU results and aligned loads to the register file
// Optional retired-instruction counter instret_o is built when WBU_PERF_CNT_EN is defined.
module wbu
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] alu_res_i,
  input  logic [4:0]            rd_i,
  input  logic                  wen_i,
  input  logic                  is_load_i,
  input  logic [2:0]            ld_funct3_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rf_wen_o,
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  retire_o
`ifdef WBU_PERF_CNT_EN
  ,
  output logic [63:0]           instret_o
`endif
);

  wbu_state_e            state_q, state_d;
  logic [4:0]            pend_rd_q, pend_rd_d;
  logic                  pend_wen_q, pend_wen_d;
  logic [2:0]            pend_f3_q, pend_f3_d;
  logic [2:0]            pend_off_q, pend_off_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic                  wb_wen_q, wb_wen_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  xfer;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata_i  (mem_rdata_i),
    .addr_i   (pend_off_q),
    .funct3_i (pend_f3_q),
    .data_o   (load_data)
  );

  assign in_ready_o = (state_q != ST_WAIT_MEM);
  assign xfer       = in_valid_i && in_ready_o;
  assign retire_o   = (state_q == ST_WB);
  assign rf_wen_o   = retire_o && wb_wen_q && (wb_rd_q != 5'd0);
  assign rf_waddr_o = wb_rd_q;
  assign rf_wdata_o = wb_data_q;

  // The wb_* registers only change on entry to WB, so the write port holds its last value elsewhere.
  always_comb begin
    state_d    = state_q;
    pend_rd_d  = pend_rd_q;
    pend_wen_d = pend_wen_q;
    pend_f3_d  = pend_f3_q;
    pend_off_d = pend_off_q;
    wb_rd_d    = wb_rd_q;
    wb_wen_d   = wb_wen_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      ST_IDLE, ST_WB: begin
        state_d = ST_IDLE;
        if (xfer) begin
          if (is_load_i) begin
            state_d    = ST_WAIT_MEM;
            pend_rd_d  = rd_i;
            pend_wen_d = wen_i;
            pend_f3_d  = ld_funct3_i;
            pend_off_d = alu_res_i[2:0];
          end else begin
            state_d   = ST_WB;
            wb_rd_d   = rd_i;
            wb_wen_d  = wen_i;
            wb_data_d = alu_res_i;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid_i) begin
          state_d   = ST_WB;
          wb_rd_d   = pend_rd_q;
          wb_wen_d  = pend_wen_q;
          wb_data_d = load_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pend_rd_q  <= '0;
      pend_wen_q <= 1'b0;
      pend_f3_q  <= '0;
      pend_off_q <= '0;
      wb_rd_q    <= '0;
      wb_wen_q   <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      pend_wen_q <= pend_wen_d;
      pend_f3_q  <= pend_f3_d;
      pend_off_q <= pend_off_d;
      wb_rd_q    <= wb_rd_d;
      wb_wen_q   <= wb_wen_d;
      wb_data_q  <= wb_data_d;
    end
  end

`ifdef WBU_PERF_CNT_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (retire_o) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_wbu.sv
// tb/tb_wbu.sv - self-checking bench for wbu; build with WBU_PERF_CNT_EN to cover instret_o
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, wen, is_load, mem_rvalid;
  logic [63:0] alu_res, mem_rdata;
  logic [4:0]  rd;
  logic [2:0]  ld_funct3;
  logic        rf_wen, retire;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
`ifdef WBU_PERF_CNT_EN
  logic [63:0] instret;
`endif

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [4:0]  last_rd = '0;
  logic [63:0] last_data = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  wbu #(.DATA_WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .alu_res_i    (alu_res),
    .rd_i         (rd),
    .wen_i        (wen),
    .is_load_i    (is_load),
    .ld_funct3_i  (ld_funct3),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .rf_wen_o     (rf_wen),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .retire_o     (retire)
`ifdef WBU_PERF_CNT_EN
    ,
    .instret_o    (instret)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Loads described by access size in bytes rather than by bit slices.
  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [2:0] addr,
                                             input logic [63:0] rdata);
    int          size;
    int          off;
    logic [63:0] mask;
    logic [63:0] field;
    if (f3 == 3'd7) return 64'd0;
    size  = 1 << f3[1:0];
    off   = int'(addr) & ~(size - 1);
    field = rdata >> (off * 8);
    mask  = (size == 8) ? '1 : ((64'd1 << (size * 8)) - 64'd1);
    field = field & mask;
    if (!f3[2] && size < 8 && field[size*8-1]) field = field | ~mask;
    return field;
  endfunction

  always @(negedge clk) begin : compare
    wr_t e;
    if (!rst_n) begin
      last_rd   = '0;
      last_data = '0;
    end else if (retire) begin
      if (exp_q.size() == 0) begin
        check("extra_retire", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("waddr", rf_waddr, e.rd);
        check("wdata", rf_wdata, e.data);
        check("rf_wen", rf_wen, e.wen && (e.rd != 5'd0));
        last_rd   = e.rd;
        last_data = e.data;
      end
    end else begin
      check("wen_outside_wb", rf_wen, 64'd0);
      check("waddr_hold", rf_waddr, last_rd);
      check("wdata_hold", rf_wdata, last_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present_alu(input logic [4:0] r, input logic w, input logic [63:0] d);
    wr_t t;
    in_valid = 1'b1;
    is_load  = 1'b0;
    rd       = r;
    wen      = w;
    alu_res  = d;
    t.wen = w; t.rd = r; t.data = d;
    exp_q.push_back(t);
  endtask

  // Presents a load, waits `delay` cycles in WAIT_MEM, then returns the data; ends in WB.
  task automatic do_load(input logic [2:0] f3, input logic [2:0] addr, input logic [63:0] rdata,
                         input int delay, input logic [4:0] r);
    wr_t t;
    in_valid  = 1'b1;
    is_load   = 1'b1;
    ld_funct3 = f3;
    rd        = r;
    wen       = 1'b1;
    alu_res   = 64'h0000_0000_8000_1000 + {61'd0, addr};
    t.wen = 1'b1; t.rd = r; t.data = model_load(f3, addr, rdata);
    exp_q.push_back(t);
    step();
    in_valid = 1'b0;
    is_load  = 1'b0;
    for (int k = 0; k < delay; k++) begin
      check("ready_low_wait", in_ready, 64'd0);
      mem_rdata = ~rdata;
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    check("ready_low_rvalid", in_ready, 64'd0);
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check("load_retire", retire, 64'd1);
  endtask

  initial begin
    in_valid = 0; wen = 0; is_load = 0; mem_rvalid = 0;
    alu_res = '0; mem_rdata = '0; rd = '0; ld_funct3 = '0;
    step();
    step();
    check("rst_retire", retire, 64'd0);
    check("rst_rf_wen", rf_wen, 64'd0);
    check("rst_waddr", rf_waddr, 64'd0);
    check("rst_wdata", rf_wdata, 64'd0);
    rst_n = 1'b1;
    step();
    check("ready_after_reset", in_ready, 64'd1);

    present_alu(5'd5, 1'b1, 64'h1234);
    step();
    in_valid = 1'b0;
    check("alu_retire", retire, 64'd1);
    check("alu_rf_wen", rf_wen, 64'd1);
    check("alu_waddr", rf_waddr, 64'd5);
    check("alu_wdata", rf_wdata, 64'h1234);
    step();
    check("alu_retire_once", retire, 64'd0);

    for (int i = 0; i < 3; i++) begin
      present_alu(5'(i + 1), 1'b1, 64'hA000 + 64'(i));
      check("b2b_ready", in_ready, 64'd1);
      step();
      check("b2b_retire", retire, 64'd1);
      check("b2b_wdata", rf_wdata, 64'hA000 + 64'(i));
    end
    in_valid = 1'b0;
    check("b2b_ready_end", in_ready, 64'd1);
    step();
    check("b2b_idle", retire, 64'd0);

    do_load(3'd0, 3'd3, 64'h0000_0000_8000_0000, 4, 5'd9);
    check("lb_lit", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    step();
    do_load(3'd4, 3'd3, 64'h0000_0000_8000_0000, 4, 5'd10);
    check("lbu_lit", rf_wdata, 64'h80);
    step();
    do_load(3'd5, 3'd3, 64'hF7E6_D5C4_B3A2_9180, 2, 5'd13);
    check("lhu_lit", rf_wdata, 64'hB3A2);
    step();
    do_load(3'd2, 3'd7, 64'hF7E6_D5C4_B3A2_9180, 1, 5'd14);
    check("lw_lit", rf_wdata, 64'hFFFF_FFFF_F7E6_D5C4);
    step();

    for (int i = 0; i < 8; i++) begin
      do_load(3'(i), 3'(i), 64'hF7E6_D5C4_B3A2_9180, 1, 5'd11);
      step();
      do_load(3'(i), 3'(7 - i), 64'h0123_8567_89AB_CDEF, 0, 5'd12);
      step();
    end

    mem_rvalid = 1'b1;
    mem_rdata  = '1;
    step();
    step();
    mem_rvalid = 1'b0;
    check("rvalid_idle_ignored", retire, 64'd0);

    present_alu(5'd6, 1'b1, 64'h55);
    step();
    do_load(3'd1, 3'd6, 64'h8001_2345_6789_ABCD, 1, 5'd15);
    step();

    present_alu(5'd0, 1'b1, 64'hDEAD);
    step();
    in_valid = 1'b0;
    check("x0_retire", retire, 64'd1);
    check("x0_rf_wen", rf_wen, 64'd0);
    step();
    present_alu(5'd7, 1'b0, 64'hBEEF);
    step();
    in_valid = 1'b0;
    check("nowen_rf_wen", rf_wen, 64'd0);
    step();

    in_valid = 1'b1; is_load = 1'b1; ld_funct3 = 3'd0; rd = 5'd20; wen = 1'b1;
    alu_res = 64'h1003;
    step();
    in_valid = 1'b0; is_load = 1'b0;
    step();
    check("mid_wait_ready", in_ready, 64'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", in_ready, 64'd1);
    check("async_rst_waddr", rf_waddr, 64'd0);
    check("async_rst_wdata", rf_wdata, 64'd0);
    step();
    rst_n = 1'b1;
    check("rel_ready", in_ready, 64'd1);
    step();
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h8000_0000;
    step();
    mem_rvalid = 1'b0;
    check("dropped_retire", retire, 64'd0);
    check("dropped_rf_wen", rf_wen, 64'd0);
    check("dropped_ready", in_ready, 64'd1);
    step();
    check("dropped_retire2", retire, 64'd0);

`ifdef WBU_PERF_CNT_EN
    check("instret_after_rst", instret, 64'd0);
    for (int i = 0; i < 10; i++) begin
      present_alu(5'(i + 1), 1'b1, 64'(i));
      step();
    end
    in_valid = 1'b0;
    step();
    check("instret_10", instret, 64'd10);
    force dut.instret_d = '1;
    step();
    release dut.instret_d;
    check("instret_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    present_alu(5'd3, 1'b1, 64'd7);
    step();
    in_valid = 1'b0;
    step();
    check("instret_wrap", instret, 64'd0);
`endif

    step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
